// File: rtl/datamem_arbiter.sv
// datamem_arbiter: two-port round-robin arbiter and one-cycle access sequencer
// for the single-ported datamem. Each granted request occupies IDLE -> ACCESS
// -> DONE, with a one-cycle ack pulse to the winner in DONE.
// Optional feature macro: DATAMEM_ARB_CHECK_EN enables size/alignment/range
// checking of the winning command; rejected commands get ack+err in DONE.
module datamem_arbiter #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    input  logic [3:0]  size0,
    input  logic [3:0]  size1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [63:0] rdata,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Elaboration-time sanity check of the memory size parameter
    if (MEM_SIZE <= 8 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
        $error("datamem_arbiter: MEM_SIZE must be a power of two greater than 8");
    end

    state_t      r_state;
    logic        r_last_grant;
    logic        r_winner;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err0;
    logic        r_err1;
    logic [63:0] r_rdata;
    logic [63:0] r_mem_address;
    logic        r_mem_we;
    logic        r_mem_re;
    logic [63:0] r_mem_wdata;
    logic [3:0]  r_mem_size;

    logic        w_win;
    logic        w_we;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [3:0]  w_size;
    logic        w_reject;

    // Round-robin winner selection and mux of the winning command
    always_comb begin
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_last_grant;
        end else if (req1) begin
            w_win = 1'b1;
        end
        w_we    = w_win ? we1    : we0;
        w_addr  = w_win ? addr1  : addr0;
        w_wdata = w_win ? wdata1 : wdata0;
        w_size  = w_win ? size1  : size0;
    end

`ifdef DATAMEM_ARB_CHECK_EN
    logic w_size_ok;

    // Reject bad size, misaligned or out-of-range commands; range test is
    // written as addr > MEM_SIZE - size so it cannot overflow
    always_comb begin
        w_size_ok = (w_size == 4'd1) || (w_size == 4'd2) ||
                    (w_size == 4'd4) || (w_size == 4'd8);
        w_reject  = !w_size_ok ||
                    ((w_addr & 64'(w_size - 4'd1)) != 64'd0) ||
                    (w_addr > (64'(MEM_SIZE) - 64'(w_size)));
    end
`else
    assign w_reject = 1'b0;
`endif

    // Sequencer FSM with registered memory command, ack/err and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_winner      <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_rdata       <= 64'd0;
            r_mem_address <= 64'd0;
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_mem_wdata   <= 64'd0;
            r_mem_size    <= 4'd8;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_winner     <= w_win;
                        r_last_grant <= w_win;
                        if (w_reject) begin
                            r_ack0  <= ~w_win;
                            r_ack1  <= w_win;
                            r_err0  <= ~w_win;
                            r_err1  <= w_win;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_address <= w_addr;
                            r_mem_wdata   <= w_wdata;
                            r_mem_size    <= w_size;
                            r_mem_we      <= w_we;
                            r_mem_re      <= ~w_we;
                            r_state       <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_mem_re) begin
                        r_rdata <= mem_read_data;
                    end
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_ack0   <= ~r_winner;
                    r_ack1   <= r_winner;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0             = r_ack0;
    assign ack1             = r_ack1;
    assign err0             = r_err0;
    assign err1             = r_err1;
    assign rdata            = r_rdata;
    assign mem_address      = r_mem_address;
    assign mem_write_enable = r_mem_we;
    assign mem_read_enable  = r_mem_re;
    assign mem_write_data   = r_mem_wdata;
    assign mem_xfer_size    = r_mem_size;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed testbench for datamem_arbiter with a byte-array datamem model.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0;
    logic [63:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  size0 = 4'd8, size1 = 4'd8;
    logic        ack0, ack1, err0, err1;
    logic [63:0] rdata;
    logic [63:0] mem_address;
    logic        mem_write_enable, mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    int errors = 0;
    int checks = 0;
    logic en_seen = 1'b0;

    logic [7:0] mem [0:1023];

    datamem_arbiter #(.MEM_SIZE(1024)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // datamem model: little-endian write at the clock edge, combinational read
    always @(posedge clk) begin
        if (mem_write_enable) begin
            for (int i = 0; i < 8; i++)
                if (i < int'(mem_xfer_size))
                    mem[10'(mem_address + 64'(i))] <= mem_write_data[8*i +: 8];
        end
        if (mem_write_enable || mem_read_enable) en_seen <= 1'b1;
    end

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            if (i < int'(mem_xfer_size))
                mem_read_data[8*i +: 8] = mem[10'(mem_address + 64'(i))];
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack0, ack1, err0, err1} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %b expected 0000", {ack0, ack1, err0, err1});
        end
        checks++;
        if ({mem_write_enable, mem_read_enable} !== 2'b00) begin
            errors++; $display("FAIL reset_enables: got %b expected 00", {mem_write_enable, mem_read_enable});
        end
        checks++;
        if (mem_address !== 64'd0 || mem_write_data !== 64'd0 || rdata !== 64'd0) begin
            errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", mem_address, mem_write_data, rdata);
        end
        checks++;
        if (mem_xfer_size !== 4'd8) begin
            errors++; $display("FAIL reset_size: got %0d expected 8", mem_xfer_size);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h10; size0 = 4'd8; wdata0 = 64'h1122334455667788;
        @(negedge clk);
        checks++;
        if ({mem_write_enable, mem_read_enable, ack0} !== 3'b100) begin
            errors++; $display("FAIL wr_access: we/re/ack0 got %b expected 100", {mem_write_enable, mem_read_enable, ack0});
        end
        checks++;
        if (mem_address !== 64'h10 || mem_write_data !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_cmd: addr %h data %h expected 10 / 1122334455667788", mem_address, mem_write_data);
        end
        @(negedge clk);
        checks++;
        if ({ack0, ack1, err0, mem_write_enable} !== 4'b1000) begin
            errors++; $display("FAIL wr_ack: ack0/ack1/err0/we got %b expected 1000", {ack0, ack1, err0, mem_write_enable});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b0 || mem_address !== 64'h10 || mem_xfer_size !== 4'd8) begin
            errors++; $display("FAIL idle_hold: ack0 %b addr %h size %0d expected 0 / 10 / 8", ack0, mem_address, mem_xfer_size);
        end
        we0 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_write_enable, mem_read_enable} !== 2'b01) begin
            errors++; $display("FAIL rd_access: we/re got %b expected 01", {mem_write_enable, mem_read_enable});
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL rd_ack: ack0 %b rdata %h expected 1 / 1122334455667788", ack0, rdata);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10; size0 = 4'd8;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h10; size1 = 4'd8;
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(negedge clk);
            checks++;
            if ({ack0, ack1} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || rdata !== 64'h1122334455667788) begin
                errors++; $display("FAIL tie_grant%0d: ack0/ack1 %b rdata %h expected %b / 1122334455667788",
                                   k, {ack0, ack1}, rdata, ((k % 2 == 0) ? 2'b10 : 2'b01));
            end
            @(negedge clk);
            checks++;
            if ({ack0, ack1} !== 2'b00) begin
                errors++; $display("FAIL tie_pulse%0d: ack0/ack1 %b expected 00", k, {ack0, ack1});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_subword();
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'h22; size1 = 4'd2; wdata1 = 64'hDEAD_0000_0000_BEEF;
        repeat (2) @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL sub_wr_ack: ack1 %b ack0 %b rdata %h expected 1 / 0 / 1122334455667788", ack1, ack0, rdata);
        end
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h23; size1 = 4'd1;
        repeat (2) @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || rdata !== 64'h00000000000000BE) begin
            errors++; $display("FAIL sub_rd_byte: ack1 %b rdata %h expected 1 / be", ack1, rdata);
        end
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; addr1 = 64'h22; size1 = 4'd2;
        repeat (2) @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || rdata !== 64'h000000000000BEEF) begin
            errors++; $display("FAIL sub_rd_half: ack1 %b rdata %h expected 1 / beef", ack1, rdata);
        end
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_access();
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h40; size0 = 4'd8; wdata0 = 64'hCAFEF00D12345678;
        @(negedge clk);
        checks++;
        if (mem_write_enable !== 1'b1) begin
            errors++; $display("FAIL rst_acc_we: got %b expected 1", mem_write_enable);
        end
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, ack1, mem_write_enable, mem_read_enable} !== 4'b0000 || mem_address !== 64'd0 ||
            mem_write_data !== 64'd0 || mem_xfer_size !== 4'd8 || rdata !== 64'd0) begin
            errors++; $display("FAIL rst_acc_outs: acks/en %b addr %h wdata %h size %0d rdata %h expected reset values",
                               {ack0, ack1, mem_write_enable, mem_read_enable}, mem_address, mem_write_data, mem_xfer_size, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, ack1} !== 2'b00) begin
            errors++; $display("FAIL rst_acc_noack: got %b expected 00", {ack0, ack1});
        end
        req0 = 1'b1; we0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rdata !== 64'hCAFEF00D12345678) begin
            errors++; $display("FAIL rst_acc_read: ack0 %b rdata %h expected 1 / cafef00d12345678", ack0, rdata);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

`ifdef DATAMEM_ARB_CHECK_EN
    task automatic test_check();
        en_seen = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h3; size0 = 4'd4;
        @(negedge clk);
        checks++;
        if ({ack0, err0, ack1, err1} !== 4'b1100) begin
            errors++; $display("FAIL chk_misalign: ack0/err0/ack1/err1 %b expected 1100", {ack0, err0, ack1, err1});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, err0, en_seen} !== 3'b000 || rdata !== 64'hCAFEF00D12345678) begin
            errors++; $display("FAIL chk_noaccess: ack0/err0/en_seen %b rdata %h expected 000 / cafef00d12345678",
                               {ack0, err0, en_seen}, rdata);
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'd1020; size0 = 4'd8;
        @(negedge clk);
        checks++;
        if ({ack0, err0, en_seen} !== 3'b110) begin
            errors++; $display("FAIL chk_range: ack0/err0/en_seen %b expected 110", {ack0, err0, en_seen});
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_subword();
        test_reset_access();
`ifdef DATAMEM_ARB_CHECK_EN
        test_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
